// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: ID-stage source/destination info in,
// stall and EX-aligned forward selects out.
interface hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int LATW  = 2
);
  localparam int SW = $clog2(DEPTH + 1);

  // Handshake: idvalid is the valid, !stall is the ready. An ID instruction is
  // accepted on a clock edge when idvalid && !stall && !flush; while stalled the
  // decoder holds idrs/idrsen/idwr/idrd/idlat stable, flush drops it unconditionally.
  logic                 idvalid;
  logic [NRD*AW-1:0]    idrs;
  logic [NRD-1:0]       idrsen;
  logic                 idwr;
  logic [AW-1:0]        idrd;
  logic [LATW-1:0]      idlat;
  logic                 flush;
  logic                 stall;
  logic [NRD*SW-1:0]    fwdsel;
  logic                 exvalid;
  logic [31:0]          stallcnt;

  modport master (
    output idvalid, idrs, idrsen, idwr, idrd, idlat, flush,
    input  stall, fwdsel, exvalid, stallcnt
  );

  modport slave (
    input  idvalid, idrs, idrsen, idwr, idrd, idlat, flush,
    output stall, fwdsel, exvalid, stallcnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight register writers producing EX forward selects and a
// load-use stall. Optional macro REGFILE_BYPASS_EN: write-through regfile covers WB.
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3,
  parameter int LATW  = 2,
  localparam int SW   = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rstn,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH-1:0] ent_v;
  logic [AW-1:0]    ent_dest [DEPTH];
  logic [LATW-1:0]  ent_lat  [DEPTH];

  logic [NRD-1:0]    hit;
  logic [NRD-1:0]    haz;
  logic [SW-1:0]     sel [NRD];
  logic [NRD*SW-1:0] fwd_next;
  logic              stall_int;
  logic              accept;

  logic [NRD*SW-1:0] fwdsel_q;
  logic              exvalid_q;
  logic [31:0]       stallcnt_q;

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  always_comb begin
    hit      = '0;
    haz      = '0;
    fwd_next = '0;
    for (int p = 0; p < NRD; p++) begin
      sel[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_v[k] && bus.idrsen[p] && (bus.idrs[p*AW +: AW] != '0) &&
            (ent_dest[k] == bus.idrs[p*AW +: AW])) begin
          hit[p] = 1'b1;
          haz[p] = (k < int'(ent_lat[k]));
          if (k == DEPTH - 1) begin
`ifdef REGFILE_BYPASS_EN
            sel[p] = '0;
`else
            sel[p] = SW'(DEPTH);
`endif
          end else begin
            sel[p] = SW'(k + 1);
          end
        end
      end
      if (hit[p] && !haz[p]) fwd_next[p*SW +: SW] = sel[p];
    end
  end

  assign stall_int = bus.idvalid && !bus.flush && (|haz);
  assign accept    = bus.idvalid && !stall_int && !bus.flush;

  // The back end never stalls: the scoreboard shifts every cycle, injecting a bubble
  // whenever ID does not hand over an instruction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_dest[i] <= '0;
        ent_lat[i]  <= '0;
      end
      fwdsel_q   <= '0;
      exvalid_q  <= 1'b0;
      stallcnt_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        ent_v[i]    <= ent_v[i-1];
        ent_dest[i] <= ent_dest[i-1];
        ent_lat[i]  <= ent_lat[i-1];
      end
      ent_v[0]    <= accept && bus.idwr && (bus.idrd != '0);
      ent_dest[0] <= bus.idrd;
      ent_lat[0]  <= bus.idlat;
      fwdsel_q    <= accept ? fwd_next : '0;
      exvalid_q   <= accept;
      if (stall_int && (stallcnt_q != 32'hFFFF_FFFF)) stallcnt_q <= stallcnt_q + 32'd1;
    end
  end

  assign bus.stall    = stall_int;
  assign bus.fwdsel   = fwdsel_q;
  assign bus.exvalid  = exvalid_q;
  assign bus.stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed test-plan sequences plus random traffic,
// checked against an age-based model of in-flight writers.
module tb_hazard_scoreboard;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 3;
  localparam int LATW  = 2;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int EW    = 1 + NRD * SW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.AW(AW), .NRD(NRD), .DEPTH(DEPTH), .LATW(LATW)) bus ();

  hazard_scoreboard #(.AW(AW), .NRD(NRD), .DEPTH(DEPTH), .LATW(LATW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // model: every accepted instruction remembered with the cycle it left ID
  typedef struct {
    int            n;
    logic          wr;
    logic [AW-1:0] rd;
    int            lat;
  } instr_t;

  instr_t          hist[$];
  logic [EW-1:0]   exp_q[$];
  int              cyc;
  int              n_total;
  int              n_bad;
  longint unsigned mdl_cnt;
  bit              mdl_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Youngest in-flight writer of rs decides; its stage is its age in cycles since EX.
  function automatic void ref_port(input logic [AW-1:0] rs, input logic en,
                                   output bit hz, output int fs);
    int best_n;
    int best_lat;
    int k;
    hz       = 1'b0;
    fs       = 0;
    best_n   = -1;
    best_lat = 0;
    if (!en || rs == '0) return;
    foreach (hist[i]) begin
      if (hist[i].wr && hist[i].rd == rs && (cyc - hist[i].n - 1) <= DEPTH - 1 &&
          hist[i].n > best_n) begin
        best_n   = hist[i].n;
        best_lat = hist[i].lat;
      end
    end
    if (best_n < 0) return;
    k = cyc - best_n - 1;
    if (k < best_lat)       hz = 1'b1;
    else if (k == DEPTH - 1) fs = BYPASS ? 0 : DEPTH;
    else                     fs = k + 1;
  endfunction

  // driver: present one ID cycle at a negedge, check stall, clock it, check outputs
  task automatic step(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                      input logic [1:0] en, input logic wr, input logic [AW-1:0] rd,
                      input int lat, input logic fl);
    bit            hz0, hz1;
    int            f0, f1;
    bit            acc;
    logic [EW-1:0] e;
    bus.idvalid = v;
    bus.idrs    = {rs1, rs0};
    bus.idrsen  = en;
    bus.idwr    = wr;
    bus.idrd    = rd;
    bus.idlat   = LATW'(lat);
    bus.flush   = fl;
    #1;
    ref_port(rs0, en[0], hz0, f0);
    ref_port(rs1, en[1], hz1, f1);
    mdl_stall = v && !fl && (hz0 || hz1);
    check("stall", 64'(bus.stall), 64'(mdl_stall));
    acc = v && !mdl_stall && !fl;
    exp_q.push_back(acc ? {1'b1, SW'(f1), SW'(f0)} : '0);
    if (acc) hist.push_back('{cyc, wr, rd, lat});
    @(posedge clk);
    cyc++;
    if (mdl_stall && mdl_cnt != 64'hFFFF_FFFF) mdl_cnt++;
    while (hist.size() > 0 && (cyc - hist[0].n - 1) > DEPTH - 1) hist.delete(0);
    @(negedge clk);
    e = exp_q.pop_front();
    check("exvalid", 64'(bus.exvalid), 64'(e[EW-1]));
    check("fwdsel", 64'(bus.fwdsel), 64'(e[EW-2:0]));
    check("stallcnt", 64'(bus.stallcnt), mdl_cnt);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 2'b00, 1'b0, '0, 0, 1'b0);
  endtask

  initial begin
    logic          rv, rwr, rfl;
    logic [AW-1:0] r0, r1, rrd;
    logic [1:0]    ren;
    int            rlat;

    n_total = 0; n_bad = 0; cyc = 0; mdl_cnt = 0; mdl_stall = 1'b0;
    bus.idvalid = 1'b0; bus.idrs = '0; bus.idrsen = '0; bus.idwr = 1'b0;
    bus.idrd = '0; bus.idlat = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_exvalid", 64'(bus.exvalid), 64'd0);
    check("rst_fwdsel", 64'(bus.fwdsel), 64'd0);
    check("rst_stallcnt", 64'(bus.stallcnt), 64'd0);
    rstn = 1'b1;

    // ALU back-to-back
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd5, 0, 1'b0);
    step(1'b1, 5'd5, '0, 2'b01, 1'b0, '0, 0, 1'b0);
    check("alu_fwd0", 64'(bus.fwdsel[SW-1:0]), 64'd1);
    idle(); idle(); idle();

    // load-use: one stall cycle, then forward from MEM
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd7, 1, 1'b0);
    step(1'b1, '0, 5'd7, 2'b10, 1'b0, '0, 0, 1'b0);
    step(1'b1, '0, 5'd7, 2'b10, 1'b0, '0, 0, 1'b0);
    check("lu_fwd1", 64'(bus.fwdsel[2*SW-1:SW]), 64'd2);
    check("lu_cnt", 64'(bus.stallcnt), 64'd1);
    idle(); idle(); idle();

    // distance 3
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd9, 0, 1'b0);
    step(1'b1, '0, '0, 2'b00, 1'b0, 5'd4, 0, 1'b0);
    step(1'b1, '0, '0, 2'b00, 1'b0, 5'd4, 0, 1'b0);
    step(1'b1, 5'd9, '0, 2'b01, 1'b0, '0, 0, 1'b0);
    check("dist3_fwd0", 64'(bus.fwdsel[SW-1:0]), BYPASS ? 64'd0 : 64'd3);
    idle(); idle(); idle();

    // youngest wins, then r0 never matches
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd3, 0, 1'b0);
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd3, 0, 1'b0);
    step(1'b1, 5'd3, 5'd3, 2'b11, 1'b0, '0, 0, 1'b0);
    check("young_fwd", 64'(bus.fwdsel), 64'({SW'(1), SW'(1)}));
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd0, 1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, '0, 0, 1'b0);
    check("r0_fwd", 64'(bus.fwdsel), 64'd0);
    idle(); idle(); idle();

    // flush during a load-use stall
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd7, 1, 1'b0);
    step(1'b1, '0, 5'd7, 2'b10, 1'b0, '0, 0, 1'b1);
    check("flush_exvalid", 64'(bus.exvalid), 64'd0);
    check("flush_cnt", 64'(bus.stallcnt), 64'd1);
    idle(); idle(); idle();

    // reset in the middle of traffic with three writers in flight
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd10, 0, 1'b0);
    step(1'b1, '0, '0, 2'b00, 1'b1, 5'd11, 1, 1'b0);
    step(1'b1, 5'd10, '0, 2'b01, 1'b1, 5'd12, 1, 1'b0);
    bus.idvalid = 1'b1; bus.idrs = {5'd12, 5'd12}; bus.idrsen = 2'b11; bus.idwr = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_exvalid", 64'(bus.exvalid), 64'd0);
    check("mid_rst_fwdsel", 64'(bus.fwdsel), 64'd0);
    check("mid_rst_stallcnt", 64'(bus.stallcnt), 64'd0);
    check("mid_rst_stall", 64'(bus.stall), 64'd0);
    hist.delete(); exp_q.delete(); mdl_cnt = 0;
    #2 rstn = 1'b1;
    @(negedge clk);
    step(1'b1, 5'd12, 5'd11, 2'b11, 1'b0, '0, 0, 1'b0);
    check("post_rst_fwd", 64'(bus.fwdsel), 64'd0);

    // random traffic; a stalled instruction is held until it leaves or is flushed
    rv = 1'b0; rwr = 1'b0; r0 = '0; r1 = '0; rrd = '0; ren = '0; rlat = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!mdl_stall) begin
        rv   = ($urandom_range(0, 9) < 8);
        r0   = AW'($urandom_range(0, 7));
        r1   = AW'($urandom_range(0, 7));
        ren  = 2'($urandom_range(0, 3));
        rwr  = ($urandom_range(0, 3) != 0);
        rrd  = AW'($urandom_range(0, 7));
        rlat = $urandom_range(0, DEPTH - 2);
      end
      rfl = ($urandom_range(0, 9) == 0);
      step(rv, r0, r1, ren, rwr, rrd, rlat, rfl);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised successor to the fixed 5-stage forwarding logic.
- Tracks in-flight register writers in a DEPTH-entry shift scoreboard and, for NRD source ports per ID-stage instruction, produces:
  - a registered per-port forward select, aligned with EX;
  - a combinational load-use stall.
- Sits between decode and the EX operand muxes.
- Supports configurable pipeline depth, read-port count and per-instruction result latency.

## Interface
- AW, 5: register address width.
- NRD, 2: source read ports per instruction.
- DEPTH, 3: tracked back-end stages; index 0 = EX, DEPTH-1 = WB; minimum 2.
- LATW, 2: width of latency class; must satisfy 2^LATW ≥ DEPTH-1.
- SW, derived = clog2(DEPTH+1): forward select width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- idvalid  in  1  valid instruction in ID.
- idrs  in  NRD*AW  source registers, port p at [p*AW +: AW].
- idrsen  in  NRD  per-port source-used flag.
- idwr  in  1  instruction writes a register.
- idrd  in  AW  destination register.
- idlat  in  LATW  producing-stage index (0 = EX/ALU, 1 = MEM/load, ...); valid range 0..DEPTH-2.
- flush  in  1  kill the ID instruction this cycle.
- stall  out  1  hold IF/ID; combinational.
- fwdsel  out  NRD*SW  registered EX operand select per port. 0 = register file; k = forward from stage k.
- exvalid  out  1  registered; a real instruction occupies EX.
- stallcnt  out  32  saturating count of stall cycles.

## Operation
- Entry e[i], i = 0..DEPTH-1, holds {v, dest, lat}.
  - An entry with idwr=0 or idrd=0 is stored with v=0.
  - Register 0 never matches.
- Match for port p: smallest k with e[k].v and e[k].dest == idrs[p] and idrsen[p].
  - Youngest writer wins; older matches are ignored.
- Hazard for port p: match k with k < e[k].lat. The producer cannot reach its result stage before the consumer's EX.
- stall = idvalid & !flush & (any port hazard).
- Accept = idvalid & !stall & !flush.
- Every clock edge:
  - e[i] ← e[i-1] for i ≥ 1.
  - e[0] ← {idwr & (idrd≠0), idrd, idlat} if Accept; otherwise a bubble (v=0).
  - The back end never stalls.
- On Accept, fwdsel[p] ← k+1 for a matching non-hazard port, else 0. On non-accept, all fwdsel ← 0.
- exvalid ← Accept.
- Match at k = DEPTH-1 (producer in WB): mapping depends on configuration; see below.
- stallcnt increments on each cycle with stall=1 and holds at 32'hFFFFFFFF.
- Flush and stall together: flush wins, stall=0, a bubble is inserted, and stallcnt is not incremented.

## Timing
- Reset (async, rstn=0): all e[i].v=0, fwdsel=0, exvalid=0, stallcnt=0.
  - Reset asserted mid-operation clears immediately.
  - stall reads 0 while the scoreboard is empty.
- stall is combinational from ID inputs and scoreboard state in the same cycle.
- fwdsel and exvalid have 1-cycle latency, valid during the consumer's EX cycle.
- Load-use with lat=L at match distance k stalls L-k cycles. The producer advances during the stall; the consumer is re-evaluated each cycle.
- A stalled instruction must hold idrs/idrsen/idwr/idrd/idlat stable; the block does not latch them.

## Configuration
- REGFILE_BYPASS_EN defined: the register file is write-through, so the ID read sees the WB write. A match at k = DEPTH-1 gives fwdsel=0, and the maximum fwdsel is DEPTH-1.
- REGFILE_BYPASS_EN undefined: a match at k = DEPTH-1 gives fwdsel=DEPTH. The datapath supplies a retire register holding the last WB data.

## Test plan
- ALU back-to-back (DEPTH=3):
  - Stimulus: I1 writes r5 with lat0; next cycle I2 reads r5 on port 0.
  - Response: stall=0; in I2's EX, fwdsel[0]=1 and exvalid=1.
- Load-use:
  - Stimulus: I1 writes r7 with lat1; next cycle I2 reads r7 on port 1.
  - Response: stall=1 for exactly 1 cycle, stallcnt=1; then fwdsel[1]=2.
- Distance 3:
  - Stimulus: I1 writes r9; two non-writers follow; then I4 reads r9.
  - Response: fwdsel=3 without REGFILE_BYPASS_EN, 0 with it.
- Youngest wins and r0:
  - Stimulus: I1 and I2 both write r3; I3 reads r3 on both ports.
  - Response: fwdsel=1 on both ports.
  - Stimulus: any writer to r0, then a reader of r0.
  - Response: fwdsel=0 and stall=0.
- Flush during stall:
  - Stimulus: load-use as above with flush=1 in the stall cycle.
  - Response: stall=0, exvalid=0 next cycle, stallcnt unchanged.
- Reset mid-operation:
  - Stimulus: rstn=0 between clock edges with 3 valid entries.
  - Response: exvalid, fwdsel and stallcnt are 0 immediately; a following reader of the previously written register gets fwdsel=0.
